// File: rtl/can_bit_timing_if.sv
// Signal bundle between the TQ generator / bit-stream MAC side and the CAN bit timing block.
// master drives configuration, strobes and bus level; slave is the timing block itself.
interface can_bit_timing_if #(
  parameter int TSEG1_W = 5,
  parameter int TSEG2_W = 4
);
  logic               enable;
  logic               tq_pulse;
  logic [TSEG1_W-1:0] tseg1;
  logic [TSEG2_W-1:0] tseg2;
  logic [1:0]         sjw;
  logic               hard_sync_en;
  logic               rx;
  logic               sample_point;
  logic               sampled_bit;
  logic               tx_point;
  logic [1:0]         seg_state;

  modport master (
    output enable,
    output tq_pulse,
    output tseg1,
    output tseg2,
    output sjw,
    output hard_sync_en,
    output rx,
    input  sample_point,
    input  sampled_bit,
    input  tx_point,
    input  seg_state
  );

  modport slave (
    input  enable,
    input  tq_pulse,
    input  tseg1,
    input  tseg2,
    input  sjw,
    input  hard_sync_en,
    input  rx,
    output sample_point,
    output sampled_bit,
    output tx_point,
    output seg_state
  );
endinterface

// File: rtl/can_bit_timing.sv
// CAN nominal bit timing: splits each bit into SYNC/TSEG1/TSEG2 on TQ strobes, emits
// sample/tx strobes, and applies hard sync and SJW-limited resync on falling rx edges.
module can_bit_timing #(
  parameter int TSEG1_W = 5,
  parameter int TSEG2_W = 4,
  parameter int CNT_W   = 5
) (
  input  logic            clock,
  input  logic            reset,
  can_bit_timing_if.slave bus
);
  localparam int LW = CNT_W + 1;

  typedef enum logic [1:0] {
    SEG_IDLE  = 2'd0,
    SEG_SYNC  = 2'd1,
    SEG_TSEG1 = 2'd2,
    SEG_TSEG2 = 2'd3
  } seg_e;

  seg_e               seg_q, seg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TSEG1_W-1:0] tseg1_lat_q, tseg1_lat_d;
  logic [TSEG2_W-1:0] tseg2_lat_q, tseg2_lat_d;
  logic [2:0]         sjw_lat_q, sjw_lat_d;
  logic [2:0]         lengthen_q, lengthen_d;
  logic [2:0]         shorten_q, shorten_d;
  logic               resync_done_q, resync_done_d;
  logic               rx_prev_q, rx_prev_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               sample_point_q, sample_point_d;
  logic               tx_point_q, tx_point_d;

  logic               cfg_ok;
  logic               edge_det;
  logic               hard_sync;
  logic               resync;
  logic               jump_end;
  logic               short_now;
  logic [LW-1:0]      cnt_ext;
  logic [LW-1:0]      sjw_ext;
  logic [LW-1:0]      seg1_len;
  logic [LW-1:0]      seg2_len;
  logic [LW-1:0]      remaining;
  logic [LW-1:0]      lengthen_new;
  logic [LW-1:0]      seg1_eff;
  logic [LW-1:0]      seg2_eff;

  assign cfg_ok    = bus.enable & (|bus.tseg1) & (|bus.tseg2);
  assign edge_det  = bus.enable & rx_prev_q & ~bus.rx;
  assign hard_sync = edge_det & bus.hard_sync_en;
  assign resync    = edge_det & ~bus.hard_sync_en & ~resync_done_q;

  assign cnt_ext      = LW'(cnt_q);
  assign sjw_ext      = LW'(sjw_lat_q);
  assign seg1_len     = LW'(tseg1_lat_q) + LW'(lengthen_q);
  assign seg2_len     = LW'(tseg2_lat_q) - LW'(shorten_q);
  assign remaining    = seg2_len - cnt_ext;
  assign lengthen_new = ((cnt_ext + LW'(1)) < sjw_ext) ? (cnt_ext + LW'(1)) : sjw_ext;

  // Adjustments decided this cycle already steer this cycle's end-of-segment compare.
  assign jump_end  = resync & (seg_q == SEG_TSEG2) & (remaining <= sjw_ext);
  assign short_now = resync & (seg_q == SEG_TSEG2) & (remaining > sjw_ext);
  assign seg1_eff  = (resync && (seg_q == SEG_TSEG1)) ? (LW'(tseg1_lat_q) + lengthen_new) : seg1_len;
  assign seg2_eff  = short_now ? (LW'(tseg2_lat_q) - sjw_ext) : seg2_len;

  always_comb begin
    seg_d          = seg_q;
    cnt_d          = cnt_q;
    tseg1_lat_d    = tseg1_lat_q;
    tseg2_lat_d    = tseg2_lat_q;
    sjw_lat_d      = sjw_lat_q;
    lengthen_d     = lengthen_q;
    shorten_d      = shorten_q;
    resync_done_d  = resync_done_q;
    rx_prev_d      = bus.rx;
    sampled_bit_d  = sampled_bit_q;
    sample_point_d = 1'b0;
    tx_point_d     = 1'b0;

    if (!cfg_ok) begin
      seg_d         = SEG_IDLE;
      cnt_d         = '0;
      lengthen_d    = '0;
      shorten_d     = '0;
      resync_done_d = 1'b0;
    end else if (seg_q == SEG_IDLE) begin
      tseg1_lat_d = bus.tseg1;
      tseg2_lat_d = bus.tseg2;
      sjw_lat_d   = 3'(bus.sjw) + 3'd1;
      seg_d       = SEG_SYNC;
      cnt_d       = '0;
      tx_point_d  = 1'b1;
    end else if (hard_sync) begin
      // An edge inside SYNC_SEG already sits at the bit start, so no new tx_point.
      seg_d         = SEG_TSEG1;
      cnt_d         = '0;
      lengthen_d    = '0;
      shorten_d     = '0;
      resync_done_d = 1'b1;
      tx_point_d    = (seg_q != SEG_SYNC);
    end else begin
      case (seg_q)
        SEG_SYNC: begin
          if (bus.tq_pulse) begin
            seg_d = SEG_TSEG1;
            cnt_d = '0;
          end
        end
        SEG_TSEG1: begin
          if (resync) begin
            lengthen_d    = 3'(lengthen_new);
            resync_done_d = 1'b1;
          end
          if (bus.tq_pulse) begin
            if (cnt_ext == seg1_eff - LW'(1)) begin
              sample_point_d = 1'b1;
              sampled_bit_d  = bus.rx;
              resync_done_d  = 1'b0;
              lengthen_d     = '0;
              shorten_d      = '0;
              seg_d          = SEG_TSEG2;
              cnt_d          = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        SEG_TSEG2: begin
          if (jump_end) begin
            // The edge's own TQ becomes SYNC_SEG of the next bit.
            tx_point_d    = 1'b1;
            seg_d         = SEG_TSEG1;
            cnt_d         = '0;
            lengthen_d    = '0;
            shorten_d     = '0;
            resync_done_d = 1'b1;
          end else begin
            if (short_now) begin
              shorten_d     = sjw_lat_q;
              resync_done_d = 1'b1;
            end
            if (bus.tq_pulse) begin
              if (cnt_ext == seg2_eff - LW'(1)) begin
                tx_point_d = 1'b1;
                seg_d      = SEG_SYNC;
                cnt_d      = '0;
                shorten_d  = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          seg_d = SEG_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q          <= SEG_IDLE;
      cnt_q          <= '0;
      tseg1_lat_q    <= '0;
      tseg2_lat_q    <= '0;
      sjw_lat_q      <= '0;
      lengthen_q     <= '0;
      shorten_q      <= '0;
      resync_done_q  <= 1'b0;
      rx_prev_q      <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_point_q <= 1'b0;
      tx_point_q     <= 1'b0;
    end else begin
      seg_q          <= seg_d;
      cnt_q          <= cnt_d;
      tseg1_lat_q    <= tseg1_lat_d;
      tseg2_lat_q    <= tseg2_lat_d;
      sjw_lat_q      <= sjw_lat_d;
      lengthen_q     <= lengthen_d;
      shorten_q      <= shorten_d;
      resync_done_q  <= resync_done_d;
      rx_prev_q      <= rx_prev_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_point_q <= sample_point_d;
      tx_point_q     <= tx_point_d;
    end
  end

  assign bus.sample_point = sample_point_q;
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.tx_point     = tx_point_q;
  assign bus.seg_state    = seg_q;
endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: table-driven bit-period checks, directed sync corner cases and a
// randomized phase, all cross-checked every cycle against a bit-position reference model.
module tb_can_bit_timing;
  logic clock;
  logic reset;

  can_bit_timing_if #(.TSEG1_W(5), .TSEG2_W(4)) bus ();

  can_bit_timing #(.TSEG1_W(5), .TSEG2_W(4), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit tq_auto = 1'b1;
  int tq_ph   = 0;

  // Reference model: bit described as a TQ position (0 = SYNC_SEG) with segment
  // boundaries recomputed from the latched lengths and the pending adjustments.
  int m_active, m_pos, m_len, m_shr, m_rd, m_rx_prev, m_sampled;
  int m_c1, m_c2, m_sjw;
  bit exp_sp, exp_tx;

  function automatic int exp_seg();
    if (m_active == 0) return 0;
    if (m_pos == 0) return 1;
    if (m_pos < 1 + m_c1 + m_len) return 2;
    return 3;
  endfunction

  task automatic model_step();
    bit edge_m;
    bit jumped;
    int b1;
    int bend;
    edge_m = bus.enable && (m_rx_prev == 1) && !bus.rx;
    exp_sp = 1'b0;
    exp_tx = 1'b0;
    jumped = 1'b0;
    if (reset) begin
      m_active = 0; m_pos = 0; m_len = 0; m_shr = 0; m_rd = 0; m_sampled = 1;
    end else if (!bus.enable || bus.tseg1 == 0 || bus.tseg2 == 0) begin
      m_active = 0; m_pos = 0; m_len = 0; m_shr = 0; m_rd = 0;
    end else if (m_active == 0) begin
      m_active = 1; m_c1 = int'(bus.tseg1); m_c2 = int'(bus.tseg2); m_sjw = int'(bus.sjw) + 1;
      m_pos = 0; m_len = 0; m_shr = 0; m_rd = 0; exp_tx = 1'b1;
    end else if (edge_m && bus.hard_sync_en) begin
      exp_tx = (m_pos != 0);
      m_pos = 1; m_len = 0; m_shr = 0; m_rd = 1;
    end else begin
      b1   = 1 + m_c1 + m_len;
      bend = b1 + m_c2 - m_shr;
      if (edge_m && m_rd == 0 && m_pos != 0) begin
        m_rd = 1;
        if (m_pos < b1) begin
          m_len = (m_pos < m_sjw) ? m_pos : m_sjw;
          b1    = 1 + m_c1 + m_len;
          bend  = b1 + m_c2 - m_shr;
        end else if (bend - m_pos <= m_sjw) begin
          exp_tx = 1'b1; m_pos = 1; m_len = 0; m_shr = 0; jumped = 1'b1;
        end else begin
          m_shr = m_sjw;
          bend  = b1 + m_c2 - m_shr;
        end
      end
      if (!jumped && bus.tq_pulse) begin
        m_pos++;
        if (m_pos == b1) begin
          exp_sp = 1'b1; m_rd = 0; m_sampled = int'(bus.rx);
        end else if (m_pos == bend) begin
          exp_tx = 1'b1; m_pos = 0; m_len = 0; m_shr = 0;
        end
      end
    end
    m_rx_prev = reset ? 1 : int'(bus.rx);
  endtask

  task automatic tick();
    int es;
    if (tq_auto) begin
      bus.tq_pulse = (tq_ph == 3);
      tq_ph = (tq_ph + 1) % 4;
    end
    @(posedge clock);
    model_step();
    cyc++;
    @(negedge clock);
    es = exp_seg();
    tests++;
    if (int'(bus.seg_state) != es || bus.sample_point !== exp_sp || bus.tx_point !== exp_tx ||
        int'(bus.sampled_bit) != m_sampled) begin
      fails++;
      if (fails < 40)
        $display("[TB] FAIL model_cycle %0d got seg=%0d sp=%0b tx=%0b sb=%0b expected seg=%0d sp=%0b tx=%0b sb=%0d",
                 cyc, bus.seg_state, bus.sample_point, bus.tx_point, bus.sampled_bit,
                 es, exp_sp, exp_tx, m_sampled);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, expv);
    end else begin
      $display("[TB] check %s = %0d ok", name, got);
    end
  endtask

  task automatic wait_sig(input bit want_sp, input string name, output int at);
    bit hit;
    int n;
    hit = 1'b0;
    n = 0;
    at = cyc;
    while (!hit && n < 400) begin
      tick();
      n++;
      if (want_sp ? bus.sample_point : bus.tx_point) begin
        hit = 1'b1;
        at = cyc;
      end
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout got no pulse in %0d cycles expected a pulse", name, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reset, configure, and return the cycle of the second tx_point (steady TQ alignment).
  task automatic start_bits(input int t1, input int t2, input int s, input bit hse, input bit rx0,
                            output int a);
    int t0;
    do_reset();
    bus.tseg1 = 5'(t1);
    bus.tseg2 = 4'(t2);
    bus.sjw = 2'(s);
    bus.hard_sync_en = hse;
    bus.rx = rx0;
    tq_auto = 1'b1;
    tq_ph = 0;
    bus.enable = 1'b1;
    wait_sig(1'b0, "first_tx", t0);
    wait_sig(1'b0, "second_tx", a);
  endtask

  typedef struct {
    int t1;
    int t2;
    int sjw;
    int period;
    int to_sample;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c, d, e, bad;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.tq_pulse = 1'b0;
    bus.tseg1 = 5'd5;
    bus.tseg2 = 4'd3;
    bus.sjw = 2'd0;
    bus.hard_sync_en = 1'b0;
    bus.rx = 1'b1;
    m_active = 0; m_pos = 0; m_len = 0; m_shr = 0; m_rd = 0; m_rx_prev = 1; m_sampled = 1;
    m_c1 = 0; m_c2 = 0; m_sjw = 1;

    vecs[0] = '{t1: 5,  t2: 3, sjw: 0, period: 36,  to_sample: 24};
    vecs[1] = '{t1: 1,  t2: 1, sjw: 0, period: 12,  to_sample: 8};
    vecs[2] = '{t1: 16, t2: 8, sjw: 3, period: 100, to_sample: 68};
    vecs[3] = '{t1: 8,  t2: 4, sjw: 1, period: 52,  to_sample: 36};

    tick();
    check_int("reset_seg_state", int'(bus.seg_state), 0);
    check_int("reset_sampled_bit", int'(bus.sampled_bit), 1);
    check_int("reset_pulses", int'(bus.sample_point) + int'(bus.tx_point), 0);
    reset = 1'b0;

    // Nominal bit period and sample position, rx idle recessive.
    for (int i = 0; i < 4; i++) begin
      start_bits(vecs[i].t1, vecs[i].t2, vecs[i].sjw, 1'b0, 1'b1, a);
      wait_sig(1'b1, "tbl_sample", b);
      check_int($sformatf("tbl%0d_to_sample", i), b - a, vecs[i].to_sample);
      check_int($sformatf("tbl%0d_sampled_bit", i), int'(bus.sampled_bit), 1);
      wait_sig(1'b0, "tbl_tx", c);
      check_int($sformatf("tbl%0d_period", i), c - a, vecs[i].period);
    end

    // Resync in TSEG1 at counter 1 with SJW 4: lengthen by 2, then nominal again.
    start_bits(5, 3, 3, 1'b0, 1'b1, a);
    repeat (9) tick();
    bus.rx = 1'b0;
    tick();
    wait_sig(1'b1, "len_sample", b);
    check_int("len_to_sample", b - a, 32);
    check_int("len_sampled_bit", int'(bus.sampled_bit), 0);
    wait_sig(1'b0, "len_tx", c);
    check_int("len_period", c - a, 44);
    wait_sig(1'b1, "len_next_sample", d);
    wait_sig(1'b0, "len_next_tx", e);
    check_int("len_next_to_sample", d - c, 24);
    check_int("len_next_period", e - c, 36);

    // Edge in TSEG2 counter 0, SJW 4: bit ends immediately.
    start_bits(5, 3, 3, 1'b0, 1'b1, a);
    wait_sig(1'b1, "jmp_sample", b);
    bus.rx = 1'b0;
    tick();
    check_int("jmp_tx_now", int'(bus.tx_point), 1);
    check_int("jmp_seg_tseg1", int'(bus.seg_state), 2);
    c = cyc;
    wait_sig(1'b1, "jmp_next_sample", d);
    check_int("jmp_next_sample", d - c, 19);

    // Same edge with SJW 1: TSEG2 shortened to 2 TQ.
    start_bits(5, 3, 0, 1'b0, 1'b1, a);
    wait_sig(1'b1, "shr_sample", b);
    bus.rx = 1'b0;
    tick();
    check_int("shr_no_tx", int'(bus.tx_point), 0);
    wait_sig(1'b0, "shr_tx", c);
    check_int("shr_tseg2_len", c - b, 8);

    // Hard sync mid-TSEG2.
    start_bits(5, 3, 0, 1'b1, 1'b1, a);
    wait_sig(1'b1, "hs_sample", b);
    repeat (5) tick();
    bus.rx = 1'b0;
    tick();
    check_int("hs_tx_now", int'(bus.tx_point), 1);
    check_int("hs_seg_tseg1", int'(bus.seg_state), 2);
    c = cyc;
    wait_sig(1'b1, "hs_next_sample", d);
    check_int("hs_to_sample", d - c, 18);

    // Two falling edges before the sample point: only the first one counts.
    start_bits(5, 3, 3, 1'b0, 1'b1, a);
    repeat (9) tick();
    bus.rx = 1'b0;
    tick();
    bus.rx = 1'b1;
    tick();
    bus.rx = 1'b0;
    tick();
    wait_sig(1'b1, "dbl_sample", b);
    check_int("dbl_to_sample", b - a, 32);

    // Illegal TSEG1 keeps the block idle.
    do_reset();
    bus.tseg1 = 5'd0;
    bus.tseg2 = 4'd3;
    bus.enable = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.seg_state != 2'd0 || bus.sample_point || bus.tx_point) bad++;
    end
    check_int("idle_tseg1_zero", bad, 0);

    // Reset mid-TSEG1 after a dominant sample, then restart.
    start_bits(5, 3, 0, 1'b0, 1'b0, a);
    wait_sig(1'b1, "rst_sample", b);
    check_int("rst_pre_sampled_bit", int'(bus.sampled_bit), 0);
    wait_sig(1'b0, "rst_tx", c);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_int("rst_seg_state", int'(bus.seg_state), 0);
    check_int("rst_sampled_bit", int'(bus.sampled_bit), 1);
    check_int("rst_pulses", int'(bus.sample_point) + int'(bus.tx_point), 0);
    reset = 1'b0;
    tick();
    check_int("rst_restart_tx", int'(bus.tx_point), 1);
    check_int("rst_restart_seg", int'(bus.seg_state), 1);

    // Randomized phase checked cycle by cycle against the model.
    tq_auto = 1'b0;
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      bus.enable = 1'b0;
      bus.tq_pulse = 1'b0;
      tick();
      bus.tseg1 = 5'($urandom_range(1, 16));
      bus.tseg2 = 4'($urandom_range(1, 8));
      bus.sjw = 2'($urandom_range(0, 3));
      bus.hard_sync_en = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 400; i++) begin
        bus.tq_pulse = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0) bus.rx = ~bus.rx;
        if ($urandom_range(0, 63) == 0) bus.hard_sync_en = ~bus.hard_sync_en;
        bus.enable = ($urandom_range(0, 299) != 0);
        reset = ($urandom_range(0, 799) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
